// File: rtl/rr_mux4.sv
// ---------------------------------------------------------------------------
// rr_mux4 -- 4-to-1 round-robin collector with a single-entry output buffer.
//
// Merges four WIDTH-bit source channels (A..D) onto one valid/ready output
// stream. A combinational round-robin arbiter chooses which source to load.
// The chosen word is held in a one-deep registered buffer. sel reports which
// channel the buffered word came from: 00=A, 01=B, 10=C, 11=D.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   A,B,C,D    in   channel 0..3 data (WIDTH bits)
//   in_valid   in   per-channel valid, bit0=A .. bit3=D
//   in_ready   out  per-channel grant, one-hot or zero
//   data       out  buffered output word
//   sel        out  source channel of data
//   out_valid  out  buffer holds a word
//   out_ready  in   consumer accepts the word
//   grant_cnt  out  (only with RR_MUX4_GRANT_CNT_EN) four 8-bit wrapping
//                   per-channel transfer counters, [7:0]=A .. [31:24]=D
//
// Optional feature macro: RR_MUX4_GRANT_CNT_EN
// ---------------------------------------------------------------------------
module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RR_MUX4_GRANT_CNT_EN
    ,
    output logic [31:0]      grant_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [WIDTH-1:0] ch_data [4];
    logic [1:0]       cand [4];
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic             can_load;
    logic             xfer;

    assign ch_data[0] = A;
    assign ch_data[1] = B;
    assign ch_data[2] = C;
    assign ch_data[3] = D;

    // cand[k] is the channel examined at priority position k (ptr + k, mod 4).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = ptr_q + 2'(gi);
        end
    endgenerate

    // Scan from lowest priority to highest, so the highest-priority valid
    // channel is the last one written and wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[cand[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[k];
            end
        end
    end

    assign can_load = (state_q == EMPTY) || out_ready;

    // The grant is gated by rst_n so nothing is ever offered during reset.
    assign xfer     = rst_n && grant_found && can_load;
    assign in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    // Next-state / buffer update. A load always wins over a pop, which
    // gives back-to-back throughput when the consumer is ready.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d = ch_data[grant_idx];
            sel_d  = grant_idx;
            ptr_d  = grant_idx + 2'd1;
        end
        case (state_q)
            EMPTY: begin
                if (xfer) state_d = FULL;
            end
            FULL: begin
                if (xfer)           state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data      = data_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == FULL);

`ifdef RR_MUX4_GRANT_CNT_EN
    // One wrapping 8-bit transfer counter per channel.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [7:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (xfer && (grant_idx == 2'(gi))) cnt_d = cnt_q + 8'd1;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) cnt_q <= 8'd0;
                else        cnt_q <= cnt_d;
            end

            assign grant_cnt[gi*8 +: 8] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_rr_mux4.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4 -- self-checking bench for rr_mux4.
// Directed scenarios plus randomized traffic. Every cycle is compared against
// a transaction-level reference model: a round-robin pointer, a one-word
// buffer and per-channel transfer counts.
// ---------------------------------------------------------------------------
module tb_rr_mux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] A, B, C, D;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] data;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
`ifdef RR_MUX4_GRANT_CNT_EN
    logic [31:0] grant_cnt;
`endif

    rr_mux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MUX4_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vec_count  = 0;
    int miss_count = 0;

    // Reference model state.
    int   m_ptr   = 0;
    bit   m_full  = 0;
    int   m_data  = 0;
    int   m_sel   = 0;
    int   m_cnt [4] = '{0, 0, 0, 0};
    int   m_grant = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational grant mid-cycle,
    // advance the model at the edge and check the registered outputs after it.
    task automatic cycle(input logic rstn, input logic [3:0] v, input logic ordy,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        int   chv [4];
        bit   load_ok;
        logic [3:0] exp_rdy;
        rst_n = rstn; in_valid = v; out_ready = ordy;
        A = a; B = b; C = c; D = d;
        chv[0] = a; chv[1] = b; chv[2] = c; chv[3] = d;

        load_ok = !m_full || ordy;
        m_grant = -1;
        for (int k = 0; k < 4; k++) begin
            if (m_grant < 0 && v[(m_ptr + k) % 4]) m_grant = (m_ptr + k) % 4;
        end
        exp_rdy = 4'b0000;
        if (rstn && load_ok && m_grant >= 0) exp_rdy[m_grant] = 1'b1;

        @(negedge clk);
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});

        @(posedge clk);
        if (!rstn) begin
            m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (exp_rdy != 4'b0000) begin
            m_data = chv[m_grant];
            m_sel  = m_grant;
            m_full = 1;
            m_ptr  = (m_grant + 1) % 4;
            m_cnt[m_grant] = (m_cnt[m_grant] + 1) % 256;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("data", {24'd0, data}, m_data);
        chk("sel", {30'd0, sel}, m_sel);
`ifdef RR_MUX4_GRANT_CNT_EN
        chk("grant_cnt", grant_cnt,
            {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]});
`endif
        $display("cyc rst_n=%b v=%b ordy=%b rdy=%b -> ov=%b sel=%0d data=%02h",
                 rstn, v, ordy, in_ready, out_valid, sel, data);
    endtask

    logic [7:0] rr_tbl [4];

    initial begin
        rst_n = 1'b0; in_valid = 4'b0; out_ready = 1'b0;
        A = 8'h0; B = 8'h0; C = 8'h0; D = 8'h0;
        rr_tbl[0] = 8'h11; rr_tbl[1] = 8'h22; rr_tbl[2] = 8'h33; rr_tbl[3] = 8'h44;
        @(posedge clk); #1;

        // Reset held with all channels requesting.
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("rst_ready", {28'd0, in_ready}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);

        // Release: first word comes from A, then strict A,B,C,D rotation.
        cycle(1'b1, 4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("first_sel", {30'd0, sel}, 32'd0);
        chk("first_data", {24'd0, data}, 32'h11);
        for (int i = 1; i < 9; i++) begin
            cycle(1'b1, 4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
            chk("rr_data", {24'd0, data}, {24'd0, rr_tbl[i % 4]});
            chk("rr_sel", {30'd0, sel}, i % 4);
        end
        // ptr now at B. Drain, then load only C.
        cycle(1'b1, 4'b0000, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0);
        cycle(1'b1, 4'b0100, 1'b0, 8'h0, 8'h0, 8'h5A, 8'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b1111, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
            chk("bp_ready", {28'd0, in_ready}, 32'd0);
            chk("bp_data", {24'd0, data}, 32'h5A);
            chk("bp_sel", {30'd0, sel}, 32'd2);
        end
        cycle(1'b1, 4'b1111, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
        chk("bp_next_sel", {30'd0, sel}, 32'd3);

        // Sparse/wrap: B then C grants leave ptr at D; only B requests.
        cycle(1'b1, 4'b0010, 1'b1, 8'h0, 8'h21, 8'h0, 8'h0);
        cycle(1'b1, 4'b0100, 1'b1, 8'h0, 8'h0, 8'h31, 8'h0);
        cycle(1'b1, 4'b0010, 1'b1, 8'h0, 8'h9C, 8'h0, 8'h0);
        chk("sparse_sel", {30'd0, sel}, 32'd1);
        chk("sparse_data", {24'd0, data}, 32'h9C);
        cycle(1'b1, 4'b1111, 1'b1, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
        chk("sparse_next", {30'd0, sel}, 32'd2);

        // Idle: pointer must stay at D across empty cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0000, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0);
            chk("idle_ov", {31'd0, out_valid}, 32'd0);
        end
        cycle(1'b1, 4'b1111, 1'b1, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
        chk("idle_next", {30'd0, sel}, 32'd3);

        // Reset while stalled with a full buffer.
        cycle(1'b1, 4'b0001, 1'b0, 8'h77, 8'h0, 8'h0, 8'h0);
        cycle(1'b0, 4'b1111, 1'b0, 8'h77, 8'h0, 8'h0, 8'h0);
        chk("midrst_ov", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 49) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // 300 transfers from A after a reset: counter for A wraps to 44.
        cycle(1'b0, 4'b0000, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 4'b0001, 1'b1, 8'(i), 8'h0, 8'h0, 8'h0);
`ifdef RR_MUX4_GRANT_CNT_EN
        chk("cnt_300", grant_cnt, 32'h0000002C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
